// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one finished FU result per cycle onto the CDB.
// Define CDB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ack,
  input  logic                     cdb_hold,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [15:0]              cdb_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BCAST = 1'b1
  } state_t;

  state_t            r_state;
  logic              w_any;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data;
  int                w_j;

`ifdef CDB_RR_EN
  localparam int PTR_W = $clog2(NUM_FU);
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_rr_nxt;
`endif

  // Scan units starting at the pointer; first valid one wins.
  always_comb begin
    w_any  = 1'b0;
    w_tag  = '0;
    w_data = '0;
    w_j    = 0;
    fu_ack = '0;
`ifdef CDB_RR_EN
    w_rr_nxt = r_rr_ptr;
`endif
    if (!cdb_hold && !flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
`ifdef CDB_RR_EN
        w_j = int'(r_rr_ptr) + k;
        if (w_j >= NUM_FU) w_j = w_j - NUM_FU;
`else
        w_j = k;
`endif
        if (!w_any && fu_valid[w_j]) begin
          w_any       = 1'b1;
          fu_ack[w_j] = 1'b1;
          w_tag       = fu_tag[w_j*TAG_W +: TAG_W];
          w_data      = fu_data[w_j*DATA_W +: DATA_W];
`ifdef CDB_RR_EN
          w_rr_nxt = (w_j == NUM_FU-1) ? '0 : PTR_W'(w_j + 1);
`endif
        end
      end
    end
  end

  assign cdb_valid = (r_state == ST_BCAST);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_count <= '0;
`ifdef CDB_RR_EN
      r_rr_ptr  <= '0;
`endif
    end else if (flush) begin
      r_state  <= ST_IDLE;
`ifdef CDB_RR_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE, ST_BCAST: begin
          if (w_any) begin
            r_state   <= ST_BCAST;
            cdb_tag   <= w_tag;
            cdb_data  <= w_data;
            cdb_count <= cdb_count + 16'd1;
`ifdef CDB_RR_EN
            r_rr_ptr  <= w_rr_nxt;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vectors, directed sequences and random traffic
// against a queue-free reference model of the CDB arbiter.
module tb_cdb_arbiter;
  logic         clk;
  logic         nRST;
  logic [3:0]   fu_valid;
  logic [15:0]  fu_tag;
  logic [127:0] fu_data;
  logic [3:0]   fu_ack;
  logic         cdb_hold;
  logic         flush;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [15:0]  cdb_count;

  cdb_arbiter #(.NUM_FU(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .nRST(nRST),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_ack(fu_ack), .cdb_hold(cdb_hold), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_count(cdb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr;
  int          m_cnt;
  logic        m_v;
  logic [3:0]  m_tag;
  logic [31:0] m_data;
  logic [3:0]  last_ack;

  typedef struct {
    logic [3:0] v;
    logic       h;
    logic       f;
    logic [3:0] ack;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] model_ack(input logic [3:0] v,
                                           input logic h, input logic f);
    int start;
    model_ack = 4'b0000;
    if (h || f) return model_ack;
`ifdef CDB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) begin
        model_ack[(start + k) % 4] = 1'b1;
        return model_ack;
      end
    end
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_v = 0; m_tag = 0; m_data = 0;
  endtask

  task automatic rnd_payload();
    for (int i = 0; i < 4; i++) begin
      fu_tag[i*4 +: 4]   = 4'($urandom);
      fu_data[i*32 +: 32] = $urandom;
    end
  endtask

  // called at negedge; returns at the following negedge
  task automatic step(input logic [3:0] v, input logic h, input logic f);
    logic [3:0] ea;
    int g;
    fu_valid = v; cdb_hold = h; flush = f;
    #1;
    ea = model_ack(v, h, f);
    chk("ack", {60'd0, fu_ack}, {60'd0, ea});
    chk("hold_valid", {63'd0, cdb_valid}, {63'd0, m_v});
    last_ack = fu_ack;
    @(posedge clk);
    if (f) begin
      m_v = 0; m_ptr = 0;
    end else if (ea != 0) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (ea[i]) g = i;
      m_v = 1;
      m_tag = fu_tag[g*4 +: 4];
      m_data = fu_data[g*32 +: 32];
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (g + 1) % 4;
    end else begin
      m_v = 0;
    end
    #1;
    chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_v});
    chk("cdb_tag", {60'd0, cdb_tag}, {60'd0, m_tag});
    chk("cdb_data", {32'd0, cdb_data}, {32'd0, m_data});
    chk("cdb_count", {48'd0, cdb_count}, 64'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] seq_ack [4];
    nRST = 0; fu_valid = 0; cdb_hold = 0; flush = 0;
    fu_tag = 0; fu_data = 0;
    model_reset();
    #3;
    chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
    chk("rst_tag", {60'd0, cdb_tag}, 64'd0);
    chk("rst_data", {32'd0, cdb_data}, 64'd0);
    chk("rst_count", {48'd0, cdb_count}, 64'd0);
    chk("rst_ack", {60'd0, fu_ack}, 64'd0);

    // combinational grant with pointer at reset value
    tbl[0] = '{4'b0000, 0, 0, 4'b0000};
    tbl[1] = '{4'b0100, 0, 0, 4'b0100};
    tbl[2] = '{4'b1010, 0, 0, 4'b0010};
    tbl[3] = '{4'b1111, 0, 0, 4'b0001};
    tbl[4] = '{4'b1000, 0, 0, 4'b1000};
    tbl[5] = '{4'b1111, 1, 0, 4'b0000};
    tbl[6] = '{4'b1111, 0, 1, 4'b0000};
    tbl[7] = '{4'b0110, 1, 1, 4'b0000};
    tbl[8] = '{4'b0110, 0, 0, 4'b0010};
    tbl[9] = '{4'b1100, 0, 0, 4'b0100};
    for (int i = 0; i < 10; i++) begin
      fu_valid = tbl[i].v; cdb_hold = tbl[i].h; flush = tbl[i].f;
      #1;
      chk($sformatf("vec%0d", i), {60'd0, fu_ack}, {60'd0, tbl[i].ack});
    end
    fu_valid = 0; cdb_hold = 0; flush = 0;

    @(negedge clk);
    nRST = 1;
    @(negedge clk);

    // single grant, tag 5 / data AA from unit 2
    rnd_payload();
    fu_tag[8 +: 4] = 4'h5;
    fu_data[64 +: 32] = 32'h0000_00AA;
    step(4'b0100, 0, 0);
    chk("p1_ack", {60'd0, last_ack}, 64'b0100);
    chk("p1_tag", {60'd0, cdb_tag}, 64'h5);
    chk("p1_data", {32'd0, cdb_data}, 64'hAA);
    chk("p1_cnt", {48'd0, cdb_count}, 64'd1);
    step(4'b0000, 0, 0);

    // all four held valid; pointer is 3 after the unit-2 grant, so
    // flush first to put it back at 0
    step(4'b0000, 0, 1);
    for (int i = 0; i < 4; i++) begin
      rnd_payload();
      step(4'b1111, 0, 0);
      seq_ack[i] = last_ack;
      chk("b2b_valid", {63'd0, cdb_valid}, 64'd1);
    end
`ifdef CDB_RR_EN
    chk("rr0", {60'd0, seq_ack[0]}, 64'b0001);
    chk("rr1", {60'd0, seq_ack[1]}, 64'b0010);
    chk("rr2", {60'd0, seq_ack[2]}, 64'b0100);
    chk("rr3", {60'd0, seq_ack[3]}, 64'b1000);
`else
    for (int i = 0; i < 4; i++)
      chk("fp", {60'd0, seq_ack[i]}, 64'b0001);
`endif

    // hold for 3 cycles with unit 1 valid
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1, 0);
      chk("hold_ack", {60'd0, last_ack}, 64'd0);
      chk("hold_cv", {63'd0, cdb_valid}, 64'd0);
    end
    step(4'b0010, 0, 0);
    chk("rel_ack", {60'd0, last_ack}, 64'b0010);
    chk("rel_cv", {63'd0, cdb_valid}, 64'd1);

    // flush while a broadcast is visible
    rnd_payload();
    step(4'b0010, 0, 0);
    begin
      int c0;
      c0 = m_cnt;
      step(4'b0100, 0, 1);
      chk("fl_ack", {60'd0, last_ack}, 64'd0);
      chk("fl_cv", {63'd0, cdb_valid}, 64'd0);
      chk("fl_cnt", {48'd0, cdb_count}, 64'(c0));
    end
    step(4'b0100, 0, 0);
    chk("fl_next", {60'd0, last_ack}, 64'b0100);
    step(4'b0000, 0, 1);
    step(4'b1010, 0, 0);
    chk("fl_ptr0", {60'd0, last_ack}, 64'b0010);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rnd_payload();
      step(4'($urandom), ($urandom % 6) == 0, ($urandom % 10) == 0);
    end

    // async reset mid-broadcast
    fu_data[0 +: 32] = 32'hDEAD_BEEF;
    fu_tag[0 +: 4] = 4'hC;
    step(4'b0001, 0, 0);
    chk("db_data", {32'd0, cdb_data}, 64'hDEAD_BEEF);
    fu_valid = 0;
    #2;
    nRST = 0;
    #1;
    chk("ar_valid", {63'd0, cdb_valid}, 64'd0);
    chk("ar_tag", {60'd0, cdb_tag}, 64'd0);
    chk("ar_data", {32'd0, cdb_data}, 64'd0);
    chk("ar_cnt", {48'd0, cdb_count}, 64'd0);
    model_reset();
    @(negedge clk);
    nRST = 1;
    @(negedge clk);

    // count wrap
    while (m_cnt != 65535) step(4'b0001, 0, 0);
    chk("pre_wrap", {48'd0, cdb_count}, 64'hFFFF);
    step(4'b0001, 0, 0);
    chk("wrap", {48'd0, cdb_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
